// File: rtl/twos_complement_accumulator.sv
// Sums fixed-length blocks of signed samples into a saturating wider accumulator
// and presents each block result on a valid/ready handshake.
module twos_complement_accumulator #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 8,
  parameter int BLOCK_LEN  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic                  out_overflow
);

  localparam int CW = $clog2(BLOCK_LEN + 1);

  typedef enum logic {S_ACCUM, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_ovf;
  logic [ACC_WIDTH-1:0] r_out_sum;
  logic                 r_out_ovf;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_release;
  logic [ACC_WIDTH:0]   w_sum;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic                 w_ovf_next;

  assign w_accept  = in_valid & (r_state == S_ACCUM);
  assign w_last    = (r_cnt == CW'(BLOCK_LEN - 1));
  assign w_release = out_ready & (r_state == S_DONE);

  // One guard bit: the sum overflowed iff the two top bits disagree.
  assign w_sum = {r_acc[ACC_WIDTH-1], r_acc}
               + {{(ACC_WIDTH + 1 - DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};

  always_comb begin
    w_acc_next = w_sum[ACC_WIDTH-1:0];
    w_ovf_next = r_ovf;
    if (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]) begin
      w_ovf_next = 1'b1;
      if (w_sum[ACC_WIDTH]) w_acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else                  w_acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_ACCUM;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_ACCUM: begin
        in_ready = 1'b1;
        if (w_accept && w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_ACCUM;
      end
      default: w_state_next = S_ACCUM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_out_sum <= '0;
      r_out_ovf <= 1'b0;
    end else if (w_release) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CW'(1);
      r_ovf <= w_ovf_next;
      if (w_last) begin
        r_out_sum <= w_acc_next;
        r_out_ovf <= w_ovf_next;
      end
    end
  end

  assign out_sum      = r_out_sum;
  assign out_overflow = r_out_ovf;

endmodule

// File: tb/tb_twos_complement_accumulator.sv
// Directed bench for twos_complement_accumulator: default, narrow-accumulator
// and single-sample-block instances driven from one cycle-by-cycle vector table.
module tb_twos_complement_accumulator;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;

  logic       rdy0, val0, ovf0;
  logic [7:0] sum0;
  logic       rdy1, val1, ovf1;
  logic [4:0] sum1;
  logic       rdy2, val2, ovf2;
  logic [7:0] sum2;

  always #5 clock = ~clock;

  twos_complement_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(8), .BLOCK_LEN(4)) d0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .out_valid(val0), .out_ready(out_ready),
    .out_sum(sum0), .out_overflow(ovf0));

  twos_complement_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(5), .BLOCK_LEN(4)) d1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .out_valid(val1), .out_ready(out_ready),
    .out_sum(sum1), .out_overflow(ovf1));

  twos_complement_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(8), .BLOCK_LEN(1)) d2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(in_data), .out_valid(val2), .out_ready(out_ready),
    .out_sum(sum2), .out_overflow(ovf2));

  typedef struct {
    logic        rst;
    logic        v;
    logic [3:0]  d;
    logic        r;
    int unsigned sel;
    logic        e_rdy;
    logic        e_val;
    logic [7:0]  e_sum;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic rst, input logic v, input logic [3:0] d, input logic r,
                     input int unsigned sel, input logic e_rdy, input logic e_val,
                     input logic [7:0] e_sum, input logic e_ovf);
    vec_t x;
    x.rst = rst; x.v = v; x.d = d; x.r = r; x.sel = sel;
    x.e_rdy = e_rdy; x.e_val = e_val; x.e_sum = e_sum; x.e_ovf = e_ovf;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_dut(input string tag, input int unsigned sel, input logic e_rdy,
                         input logic e_val, input logic [7:0] e_sum, input logic e_ovf);
    logic       a_rdy, a_val, a_ovf;
    logic [7:0] a_sum;
    case (sel)
      0:       begin a_rdy = rdy0; a_val = val0; a_sum = sum0;     a_ovf = ovf0; end
      1:       begin a_rdy = rdy1; a_val = val1; a_sum = 8'(sum1); a_ovf = ovf1; end
      default: begin a_rdy = rdy2; a_val = val2; a_sum = sum2;     a_ovf = ovf2; end
    endcase
    chk({tag, ".in_ready"},     8'(a_rdy), 8'(e_rdy));
    chk({tag, ".out_valid"},    8'(a_val), 8'(e_val));
    chk({tag, ".out_sum"},      a_sum,     e_sum);
    chk({tag, ".out_overflow"}, 8'(a_ovf), 8'(e_ovf));
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Default instance: -1 x4, gapped 7,7,-8,3, backpressure then a clean block
    for (int i = 0; i < 3; i++) add(0, 1, 4'hF, 1, 0, 1, 0, 8'h00, 0);
    add(0, 1, 4'hF, 1, 0, 0, 1, 8'hFC, 0);
    add(0, 0, 4'h0, 1, 0, 1, 0, 8'hFC, 0);
    add(0, 1, 4'h7, 1, 0, 1, 0, 8'hFC, 0);
    add(0, 0, 4'h0, 1, 0, 1, 0, 8'hFC, 0);
    add(0, 1, 4'h7, 1, 0, 1, 0, 8'hFC, 0);
    add(0, 0, 4'h0, 1, 0, 1, 0, 8'hFC, 0);
    add(0, 1, 4'h8, 1, 0, 1, 0, 8'hFC, 0);
    add(0, 1, 4'h3, 1, 0, 0, 1, 8'h09, 0);
    add(0, 0, 4'h0, 1, 0, 1, 0, 8'h09, 0);
    add(0, 0, 4'h0, 1, 0, 1, 0, 8'h09, 0);
    add(0, 1, 4'h1, 0, 0, 1, 0, 8'h09, 0);
    add(0, 1, 4'h2, 0, 0, 1, 0, 8'h09, 0);
    add(0, 1, 4'h3, 0, 0, 1, 0, 8'h09, 0);
    add(0, 1, 4'h4, 0, 0, 0, 1, 8'h0A, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 4'h5, 0, 0, 0, 1, 8'h0A, 0);
    add(0, 1, 4'h5, 1, 0, 1, 0, 8'h0A, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 4'h1, 1, 0, 1, 0, 8'h0A, 0);
    add(0, 1, 4'h1, 1, 0, 0, 1, 8'h04, 0);
    add(0, 0, 4'h0, 1, 0, 1, 0, 8'h04, 0);
    // ACC_WIDTH=5 instance: positive clamp, clean block, negative clamp, exact max
    add(1, 1, 4'h7, 1, 1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 4'h7, 1, 1, 1, 0, 8'h00, 0);
    add(0, 1, 4'h8, 1, 1, 0, 1, 8'h07, 1);
    add(0, 0, 4'h0, 1, 1, 1, 0, 8'h07, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 4'h0, 1, 1, 1, 0, 8'h07, 1);
    add(0, 1, 4'h0, 1, 1, 0, 1, 8'h00, 0);
    add(0, 0, 4'h0, 1, 1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 4'h8, 1, 1, 1, 0, 8'h00, 0);
    add(0, 1, 4'h7, 1, 1, 0, 1, 8'h17, 1);
    add(0, 0, 4'h0, 1, 1, 1, 0, 8'h17, 1);
    add(0, 1, 4'h7, 1, 1, 1, 0, 8'h17, 1);
    add(0, 1, 4'h7, 1, 1, 1, 0, 8'h17, 1);
    add(0, 1, 4'h1, 1, 1, 1, 0, 8'h17, 1);
    add(0, 1, 4'h0, 1, 1, 0, 1, 8'h0F, 0);
    add(0, 0, 4'h0, 1, 1, 1, 0, 8'h0F, 0);
    // BLOCK_LEN=1 instance: -8 then 5 held valid
    add(1, 1, 4'h3, 1, 2, 1, 0, 8'h00, 0);
    add(0, 1, 4'h8, 1, 2, 0, 1, 8'hF8, 0);
    add(0, 1, 4'h5, 1, 2, 1, 0, 8'hF8, 0);
    add(0, 1, 4'h5, 1, 2, 0, 1, 8'h05, 0);
    add(0, 0, 4'h0, 1, 2, 1, 0, 8'h05, 0);

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    step();
    chk_dut("reset.d0", 0, 1, 0, 8'h00, 0);
    chk_dut("reset.d1", 1, 1, 0, 8'h00, 0);
    chk_dut("reset.d2", 2, 1, 0, 8'h00, 0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      reset     = tbl[i].rst;
      in_valid  = tbl[i].v;
      in_data   = tbl[i].d;
      out_ready = tbl[i].r;
      step();
      chk_dut($sformatf("row%0d", i), tbl[i].sel, tbl[i].e_rdy, tbl[i].e_val,
              tbl[i].e_sum, tbl[i].e_ovf);
    end

    // Reset mid-block on the default instance discards the partial sum
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b1; in_data = 4'h3;
    step();
    step();
    chk_dut("abort.pre", 0, 1, 0, 8'h00, 0);
    reset = 1'b1;
    step();
    chk_dut("abort.rst", 0, 1, 0, 8'h00, 0);
    reset = 1'b0; in_data = 4'h1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_dut($sformatf("abort.s%0d", i), 0, 1, 0, 8'h00, 0);
    end
    step();
    chk_dut("abort.result", 0, 0, 1, 8'h04, 0);
    in_valid = 1'b0;
    step();
    chk_dut("abort.release", 0, 1, 0, 8'h04, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
